// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with fixed access latency and RV32I sub-word load/store
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic [29:0] widx;
  logic [IW-1:0] idx;
  logic [31:0] word, ld, mask, wd;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic        err, go;
  logic [31:0] mem [DEPTH_WORDS];
  assign req_ready = (state == IDLE) & ~rst;
  assign widx = 30'((addr - ADDR_BASE) >> 2);
  assign idx  = widx[IW-1:0];
  // WAIT always lasts WAIT_CYCLES+1 cycles so the response rises WAIT_CYCLES+1 edges after accept
  assign go   = (state == WAIT) && (cnt == 4'd0);
  always_comb begin
    err  = (f3 == 3'd3) | (f3[2] & (wr | f3[1])) | (f3[0] & ~f3[1] & addr[0]) |
           ((f3 == 3'd2) & |addr[1:0]) | (addr < ADDR_BASE) | ({2'b0, widx} >= DEPTH_WORDS);
    word = mem[idx];
    bsel = 8'(word >> {addr[1:0], 3'b0});
    hsel = 16'(word >> {addr[1], 4'b0});
    ld   = f3 == 3'd0 ? {{24{bsel[7]}}, bsel} :
           f3 == 3'd4 ? {24'b0, bsel} :
           f3 == 3'd1 ? {{16{hsel[15]}}, hsel} :
           f3 == 3'd5 ? {16'b0, hsel} : word;
    mask = f3 == 3'd0 ? 32'hFF << {addr[1:0], 3'b0} :
           f3 == 3'd1 ? 32'hFFFF << {addr[1], 4'b0} : '1;
    wd   = f3 == 3'd0 ? {4{wdata[7:0]}} : f3 == 3'd1 ? {2{wdata[15:0]}} : wdata;
  end
  always_ff @(posedge clk)
    if (go & wr & ~err) mem[idx] <= (word & ~mask) | (wd & mask);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr         <= 1'b0;
      f3         <= '0;
      addr       <= '0;
      wdata      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= WAIT;
          cnt   <= 4'(WAIT_CYCLES);
          wr    <= req_write;
          f3    <= req_funct3;
          addr  <= req_addr;
          wdata <= req_wdata;
        end
        WAIT: if (go) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= (err | wr) ? '0 : ld;
          resp_err   <= err;
        end else cnt <= cnt - 4'd1;
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized load/store traffic checked against a byte-addressed memory model
module tb_dmem_responder;
  localparam int WC = 2;
  localparam int DW = 1024;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_err;
  logic [2:0]  z_req_funct3;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
  int errors = 0, checks = 0;
  logic [7:0] mm [DW*4];

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .resp_valid(z_resp_valid),
    .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = wr ? (f3 == 0 || f3 == 1 || f3 == 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    return !legal || ((f3 == 1 || f3 == 5) && a % 2 != 0) || (f3 == 2 && a % 4 != 0) || a >= 32'(DW * 4);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int i = int'(a);
    int w = i - i % 4;
    case (f3)
      3'd0: return 32'($signed(mm[i]));
      3'd4: return {24'b0, mm[i]};
      3'd1: return 32'($signed({mm[i+1], mm[i]}));
      3'd5: return {16'b0, mm[i+1], mm[i]};
      default: return {mm[w+3], mm[w+2], mm[w+1], mm[w]};
    endcase
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int i = int'(a);
    mm[i] = d[7:0];
    if (f3 != 0) mm[i+1] = d[15:8];
    if (f3 == 2) begin
      mm[i+2] = d[23:16];
      mm[i+3] = d[31:24];
    end
  endtask

  task automatic scramble();
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
    logic ee;
    logic [31:0] exp;
    int n = 0;
    ee  = m_err(wr, f3, a);
    exp = (ee || wr) ? 32'h0 : m_load(f3, a);
    @(negedge clk);
    req_valid = 1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 0;
    scramble();
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, WC + 1);
    chk("rdata", resp_rdata, exp);
    chk("err", {31'b0, resp_err}, {31'b0, ee});
    rd = resp_rdata;
    if (!ee && wr) m_store(f3, a, d);
    @(posedge clk); #1;
    chk("resp_drop", {31'b0, resp_valid}, 0);
  endtask

  task automatic zx(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    z_req_valid = 1; z_req_write = wr; z_req_funct3 = f3; z_req_addr = a; z_req_wdata = d;
    @(posedge clk); #1;
    z_req_valid = 0;
    while (!z_resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("z_latency", n, 1);
    rd = z_resp_rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, old;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        wr;
    int n;
    req_valid = 0; resp_ready = 1; scramble();
    z_req_valid = 0; z_resp_ready = 1; z_req_write = 0; z_req_funct3 = 0; z_req_addr = 0; z_req_wdata = 0;
    #2;
    chk("rst_valid", {31'b0, resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0; #1;
    chk("ready_after_rst", {31'b0, req_ready}, 1);
    for (int i = 0; i < 64; i++) xact(1, 3'd2, 32'(i * 4), $urandom, rd);
    xact(1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    xact(0, 3'd2, 32'h10, 0, rd);  chk("lw_10", rd, 32'hDEADBEEF);
    xact(1, 3'd0, 32'h11, 32'h7F, rd);
    xact(0, 3'd2, 32'h10, 0, rd);  chk("sb_merge", rd, 32'hDEAD7FEF);
    xact(0, 3'd0, 32'h13, 0, rd);  chk("lb", rd, 32'hFFFFFFDE);
    xact(0, 3'd4, 32'h13, 0, rd);  chk("lbu", rd, 32'h000000DE);
    xact(0, 3'd1, 32'h12, 0, rd);  chk("lh", rd, 32'hFFFFDEAD);
    xact(0, 3'd5, 32'h12, 0, rd);  chk("lhu", rd, 32'h0000DEAD);
    xact(0, 3'd2, 32'h12, 0, rd);
    xact(1, 3'd1, 32'h11, 32'h5555, rd);
    xact(0, 3'd0, 32'(DW * 4), 0, rd);
    xact(0, 3'd3, 32'h10, 0, rd);
    xact(1, 3'd4, 32'h10, 32'h0, rd);
    xact(0, 3'd2, 32'h10, 0, rd);  chk("word_unchanged", rd, 32'hDEAD7FEF);
    // back-pressure: response held, a new request waits until the response is taken
    @(negedge clk);
    resp_ready = 0; req_valid = 1; req_write = 0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_addr = 32'h14;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("hold_latency", n, WC + 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 1);
      chk("hold_rdata", resp_rdata, 32'hDEAD7FEF);
      chk("hold_ready", {31'b0, req_ready}, 0);
    end
    @(negedge clk); resp_ready = 1;
    @(posedge clk); #1;
    chk("released_valid", {31'b0, resp_valid}, 0);
    chk("released_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    chk("pending_accepted", {31'b0, req_ready}, 0);
    req_valid = 0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("pending_latency", n, WC + 1);
    chk("pending_rdata", resp_rdata, m_load(3'd2, 32'h14));
    @(posedge clk); #1;
    // asynchronous reset while a response is held
    @(negedge clk);
    resp_ready = 0; req_valid = 1; req_write = 0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    #2 rst = 1; #1;
    chk("async_valid", {31'b0, resp_valid}, 0);
    chk("async_rdata", resp_rdata, 0);
    chk("async_err", {31'b0, resp_err}, 0);
    @(negedge clk); rst = 0; resp_ready = 1; #1;
    chk("async_ready", {31'b0, req_ready}, 1);
    // reset while a store waits: storage must keep the old word
    old = m_load(3'd2, 32'h20);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk); rst = 1; #1;
    chk("wait_rst_valid", {31'b0, resp_valid}, 0);
    @(negedge clk); rst = 0;
    xact(0, 3'd2, 32'h20, 0, rd);  chk("dropped_store", rd, old);
    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom);
      f3 = $urandom_range(0, 9) == 0 ? 3'($urandom) :
           wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4) > 2 ? $urandom_range(4, 5) : $urandom_range(0, 2));
      n = $urandom_range(0, 19);
      a = n == 0 ? $urandom : n == 1 ? 32'(DW * 4) + $urandom_range(0, 15) : 32'($urandom_range(0, 255));
      xact(wr, f3, a, $urandom, rd);
    end
    zx(1, 3'd2, 32'h20, 32'h12345678, rd);
    zx(0, 3'd2, 32'h20, 0, rd);  chk("z_lw", rd, 32'h12345678);
    zx(1, 3'd0, 32'h22, 32'hAB, rd);
    zx(0, 3'd4, 32'h22, 0, rd);  chk("z_lbu", rd, 32'h000000AB);
    zx(0, 3'd2, 32'h20, 0, rd);  chk("z_merge", rd, 32'h12AB5678);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
